// File: rtl/proc_ctrl_sequencer.sv
// rtl/proc_ctrl_sequencer.sv - T0..T3 control sequencer for the 9-bit bus processor (optional mvnz: PROC_CTRL_MVNZ_EN)
module proc_ctrl_sequencer #(
  parameter int IW   = 9,
  parameter int NREG = 8
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IW-1:0]   DIn,
  input  logic            Gnz,
  output logic [NREG-1:0] Rout,
  output logic            Gout,
  output logic            DIn_out,
  output logic            ones_out,
  output logic [NREG-1:0] Rin,
  output logic            Ain,
  output logic            Gin,
  output logic            IRin,
  output logic            AddSub,
  output logic            Done,
  output logic            Busy
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  localparam logic [NREG-1:0] REG_BIT0 = NREG'(1);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ir;
  logic [2:0]      opcode;
  logic [2:0]      fld_x;
  logic [2:0]      fld_y;
  logic [NREG-1:0] x_dec;
  logic [NREG-1:0] y_dec;
  logic            alu_op;
  logic            mvnz_take;

  assign opcode = ir[IW-1:IW-3];
  assign fld_x  = ir[IW-4:IW-6];
  assign fld_y  = ir[IW-7:IW-9];
  assign x_dec  = REG_BIT0 << fld_x;
  assign y_dec  = REG_BIT0 << fld_y;

  // add/sub/inc/dec are the only instructions that need T2 and T3
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_INC) || (opcode == OP_DEC);

`ifdef PROC_CTRL_MVNZ_EN
  assign mvnz_take = (opcode == OP_MVNZ) && Gnz;
`else
  logic gnz_unused;
  assign gnz_unused = Gnz;
  assign mvnz_take  = 1'b0;
`endif

  // State register; reset parks the sequencer in T0 without waiting for a clock
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= T0;
    else         state <= state_nxt;
  end

  // Instruction latch: captured only on the fetch edge out of T0
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                  ir <= '0;
    else if (state == T0 && Run)  ir <= DIn;
  end

  // Next-state: single-step instructions finish in T1, ALU ops walk to T3
  always_comb begin
    state_nxt = state;
    unique case (state)
      T0: state_nxt = Run ? T1 : T0;
      T1: state_nxt = alu_op ? T2 : T0;
      T2: state_nxt = T3;
      T3: state_nxt = T0;
      default: state_nxt = T0;
    endcase
  end

  // Output decode from state and latched instruction; only one bus source per cycle
  always_comb begin
    Rout     = '0;
    Gout     = 1'b0;
    DIn_out  = 1'b0;
    ones_out = 1'b0;
    Rin      = '0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    IRin     = 1'b0;
    AddSub   = 1'b0;
    Done     = 1'b0;
    unique case (state)
      T0: IRin = Run & Resetn;
      T1: begin
        unique case (opcode)
          OP_MV: begin
            Rout = y_dec;
            Rin  = x_dec;
            Done = 1'b1;
          end
          OP_MVI: begin
            DIn_out = 1'b1;
            Rin     = x_dec;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            Rout = x_dec;
            Ain  = 1'b1;
          end
          OP_MVNZ: begin
            Done = 1'b1;
            if (mvnz_take) begin
              Rout = y_dec;
              Rin  = x_dec;
            end
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        // inc/dec (opcode[2]=1) use the constant one instead of Ry
        if (opcode[2]) ones_out = 1'b1;
        else           Rout     = y_dec;
        Gin    = 1'b1;
        AddSub = opcode[0];
      end
      T3: begin
        Gout = 1'b1;
        Rin  = x_dec;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign Busy = (state != T0);

endmodule
